// File: rtl/pio_read_serializer_pkg.sv
// Shared widths and FSM encoding for the LVDA PIO read return path.
package pio_read_serializer_pkg;

    localparam int LVDC_WORD_W = 26;
    localparam int PIO_ADDR_W  = 9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_ALIGN = 2'd2,
        ST_SHIFT = 2'd3
    } rd_state_t;

endpackage

// File: rtl/pio_shift_out.sv
// Parallel-load, strobe-enabled LSB-first shift register; counts bits already
// taken from dout and saturates at N so it can never wrap.
module pio_shift_out #(
    parameter int N     = 27,
    parameter int CNT_W = $clog2(N + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [N-1:0] din,
    input  logic         stb,
    output logic         dout,
    output logic         last
);

    logic [N-1:0]     shift_reg;
    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_reg <= '0;
            cnt_reg   <= '0;
        end else if (load) begin
            shift_reg <= din;
            cnt_reg   <= '0;
        end else if (stb && !last) begin
            shift_reg <= shift_reg >> 1;
            cnt_reg   <= cnt_reg + 1'b1;
        end
    end

    assign dout = shift_reg[0];
    // All N bits have been handed out; further strobes are ignored.
    assign last = (cnt_reg == CNT_W'(N));

endmodule

// File: rtl/pio_read_serializer.sv
// PIO read return path: fetch a word from the addressed LVDA source, wait for
// word sync, then shift it to the LVDC on DINF, one bit per bit-time strobe.
module pio_read_serializer
    import pio_read_serializer_pkg::*;
#(
    parameter int WORD_W    = LVDC_WORD_W,
    parameter int ADDR_W    = PIO_ADDR_W,
    parameter int TIMEOUT   = 32,
    parameter int PARITY_EN = 1
) (
    input  logic              SIM_CLK,
    input  logic              SIM_RST,
    input  logic              BIT_STB,
    input  logic              WORD_SYNC,
    input  logic              RD_REQ,
    input  logic [ADDR_W-1:0] RD_ADDR,
    input  logic              SRC_ACK,
    input  logic [WORD_W-1:0] SRC_DATA,
    output logic              SRC_REQ,
    output logic [ADDR_W-1:0] SRC_ADDR,
    output logic              DINF,
    output logic              DIN_GATE,
    output logic              BUSY,
    output logic              DONE,
    output logic              TMO_ERR,
    output logic              OVR_ERR
);

    localparam int N     = WORD_W + ((PARITY_EN != 0) ? 1 : 0);
    localparam int CNT_W = $clog2(WORD_W + 2);
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    rd_state_t         state_reg;
    logic [TMO_W-1:0]  tmo_cnt_reg;
    logic              src_req_reg;
    logic [ADDR_W-1:0] src_addr_reg;
    logic              dinf_reg;
    logic              din_gate_reg;
    logic              done_reg;
    logic              tmo_err_reg;
    logic              ovr_err_reg;

    logic              fetch_ack;
    logic              fetch_tmo;
    logic              sh_load;
    logic              sh_stb;
    logic              sh_dout;
    logic              sh_last;
    logic [N-1:0]      sh_din;
    logic [WORD_W-1:0] load_word;

    assign fetch_ack = (state_reg == ST_FETCH) && SRC_ACK;
    // An ACK arriving on the expiring strobe still wins over the timeout.
    assign fetch_tmo = (state_reg == ST_FETCH) && !SRC_ACK && BIT_STB &&
                       (tmo_cnt_reg == TMO_W'(TIMEOUT - 1));
    assign sh_load   = fetch_ack || fetch_tmo;
    assign load_word = fetch_ack ? SRC_DATA : '0;

    generate
        if (PARITY_EN != 0) begin : g_parity
            // Odd parity over data+parity; an all-zero timeout word gives 1.
            assign sh_din = {~^load_word, load_word};
        end else begin : g_no_parity
            assign sh_din = load_word;
        end
    endgenerate

    assign sh_stb = BIT_STB && (((state_reg == ST_ALIGN) && WORD_SYNC) ||
                                ((state_reg == ST_SHIFT) && !sh_last));

    pio_shift_out #(
        .N     (N),
        .CNT_W (CNT_W)
    ) u_shift (
        .clk  (SIM_CLK),
        .rst  (SIM_RST),
        .load (sh_load),
        .din  (sh_din),
        .stb  (sh_stb),
        .dout (sh_dout),
        .last (sh_last)
    );

    always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
        if (SIM_RST) begin
            state_reg    <= ST_IDLE;
            tmo_cnt_reg  <= '0;
            src_req_reg  <= 1'b0;
            src_addr_reg <= '0;
            dinf_reg     <= 1'b0;
            din_gate_reg <= 1'b0;
            done_reg     <= 1'b0;
            tmo_err_reg  <= 1'b0;
            ovr_err_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            // The DONE cycle still counts as busy for incoming requests.
            if (RD_REQ && ((state_reg != ST_IDLE) || done_reg))
                ovr_err_reg <= 1'b1;

            case (state_reg)
                ST_IDLE: begin
                    if (RD_REQ && !done_reg) begin
                        src_addr_reg <= RD_ADDR;
                        tmo_err_reg  <= 1'b0;
                        ovr_err_reg  <= 1'b0;
                        src_req_reg  <= 1'b1;
                        tmo_cnt_reg  <= '0;
                        state_reg    <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (SRC_ACK) begin
                        src_req_reg <= 1'b0;
                        state_reg   <= ST_ALIGN;
                    end else if (BIT_STB) begin
                        if (fetch_tmo) begin
                            src_req_reg <= 1'b0;
                            tmo_err_reg <= 1'b1;
                            state_reg   <= ST_ALIGN;
                        end else begin
                            tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
                        end
                    end
                end
                ST_ALIGN: begin
                    if (BIT_STB && WORD_SYNC) begin
                        dinf_reg     <= sh_dout;
                        din_gate_reg <= 1'b1;
                        state_reg    <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (BIT_STB) begin
                        if (sh_last) begin
                            dinf_reg     <= 1'b0;
                            din_gate_reg <= 1'b0;
                            done_reg     <= 1'b1;
                            state_reg    <= ST_IDLE;
                        end else begin
                            dinf_reg <= sh_dout;
                        end
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign SRC_REQ  = src_req_reg;
    assign SRC_ADDR = src_addr_reg;
    assign DINF     = dinf_reg;
    assign DIN_GATE = din_gate_reg;
    assign BUSY     = (state_reg != ST_IDLE);
    assign DONE     = done_reg;
    assign TMO_ERR  = tmo_err_reg;
    assign OVR_ERR  = ovr_err_reg;

endmodule

// File: tb/tb_pio_read_serializer.sv
// Directed + randomized bench for pio_read_serializer: a free-running bit/word
// timing generator, a serial-stream monitor and a word-level reference model.
module tb_pio_read_serializer;

    localparam int WORD_W     = 26;
    localparam int ADDR_W     = 9;
    localparam int TIMEOUT    = 32;
    localparam int STB_PERIOD = 4;
    localparam int FRAME_BITS = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              bit_stb = 1'b0;
    logic              word_sync = 1'b0;
    logic              rd_req = 1'b0;
    logic [ADDR_W-1:0] rd_addr = '0;
    logic              src_ack = 1'b0;
    logic [WORD_W-1:0] src_data = '0;

    logic              src_req_p, dinf_p, gate_p, busy_p, done_p, tmo_p, ovr_p;
    logic [ADDR_W-1:0] src_addr_p;
    logic              src_req_n, dinf_n, gate_n, busy_n, done_n, tmo_n, ovr_n;
    logic [ADDR_W-1:0] src_addr_n;

    logic              sel_np = 1'b0;
    logic              m_src_req, m_dinf, m_gate, m_busy, m_done, m_tmo, m_ovr;
    logic [ADDR_W-1:0] m_src_addr;

    int tests = 0;
    int fails = 0;
    int stb_total = 0;
    bit ghost_en = 1'b0;

    always #5 clk = ~clk;

    pio_read_serializer #(.WORD_W(WORD_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT), .PARITY_EN(1)) dut (
        .SIM_CLK(clk), .SIM_RST(rst), .BIT_STB(bit_stb), .WORD_SYNC(word_sync),
        .RD_REQ(rd_req), .RD_ADDR(rd_addr), .SRC_ACK(src_ack), .SRC_DATA(src_data),
        .SRC_REQ(src_req_p), .SRC_ADDR(src_addr_p), .DINF(dinf_p), .DIN_GATE(gate_p),
        .BUSY(busy_p), .DONE(done_p), .TMO_ERR(tmo_p), .OVR_ERR(ovr_p));

    pio_read_serializer #(.WORD_W(WORD_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT), .PARITY_EN(0)) dut_np (
        .SIM_CLK(clk), .SIM_RST(rst), .BIT_STB(bit_stb), .WORD_SYNC(word_sync),
        .RD_REQ(rd_req), .RD_ADDR(rd_addr), .SRC_ACK(src_ack), .SRC_DATA(src_data),
        .SRC_REQ(src_req_n), .SRC_ADDR(src_addr_n), .DINF(dinf_n), .DIN_GATE(gate_n),
        .BUSY(busy_n), .DONE(done_n), .TMO_ERR(tmo_n), .OVR_ERR(ovr_n));

    assign m_src_req  = sel_np ? src_req_n  : src_req_p;
    assign m_src_addr = sel_np ? src_addr_n : src_addr_p;
    assign m_dinf     = sel_np ? dinf_n     : dinf_p;
    assign m_gate     = sel_np ? gate_n     : gate_p;
    assign m_busy     = sel_np ? busy_n     : busy_p;
    assign m_done     = sel_np ? done_n     : done_p;
    assign m_tmo      = sel_np ? tmo_n      : tmo_p;
    assign m_ovr      = sel_np ? ovr_n      : ovr_p;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Timing generator: one strobe every STB_PERIOD cycles, word sync on bit 0
    // of each frame, optional stray syncs that carry no strobe.
    int phase = 0;
    int bit_idx = 0;
    always @(posedge clk) begin
        #1;
        bit_stb   = (phase == 0);
        word_sync = ((phase == 0) && (bit_idx == 0)) ||
                    (ghost_en && (phase == 2) && ($urandom_range(0, 3) == 0));
        if (phase == 0) begin
            stb_total++;
            bit_idx = (bit_idx + 1) % FRAME_BITS;
        end
        phase = (phase + 1) % STB_PERIOD;
    end

    // Serial monitor: captures one bit per strobe while the gate is open.
    bit   cap_q[$];
    int   gate_cycles = 0;
    int   done_cnt = 0;
    int   cap_at_done = -1;
    logic last_stb = 1'b0, last_sync = 1'b0, prev_gate = 1'b0;
    always @(negedge clk) begin
        if (m_gate && !prev_gate)
            check("gate_rise_on_sync", {30'd0, last_stb, last_sync}, 32'd3);
        if (m_gate && last_stb) cap_q.push_back(m_dinf);
        if (m_gate) gate_cycles++;
        if (m_done) begin
            done_cnt++;
            cap_at_done = cap_q.size();
        end
        prev_gate = m_gate;
        last_stb  = bit_stb;
        last_sync = word_sync;
    end

    // Reference model: data LSB first, then a bit that makes the total ones count odd.
    bit exp_q[$];
    function automatic void build_expect(input logic [WORD_W-1:0] d, input bit with_par);
        int ones;
        ones = 0;
        exp_q.delete();
        for (int i = 0; i < WORD_W; i++) begin
            exp_q.push_back(bit'((d >> i) & 1));
            ones += int'((d >> i) & 1);
        end
        if (with_par) exp_q.push_back((ones % 2) == 0);
    endfunction

    // mode: 0 plain, 1 request during shift, 2 request on DONE cycle, 3 reset after bit 10
    task automatic run_read(input logic [ADDR_W-1:0] addr, input logic [WORD_W-1:0] data,
                            input int ack_delay, input int mode);
        int          n;
        int          base;
        bit          got_done;
        bit          injected;
        logic [31:0] obs_w;
        logic [31:0] exp_w;
        n = sel_np ? WORD_W : WORD_W + 1;
        build_expect((ack_delay < 0) ? '0 : data, !sel_np);
        cap_q.delete();
        gate_cycles = 0;
        done_cnt    = 0;
        cap_at_done = -1;

        @(posedge clk); #1;
        rd_req = 1'b1; rd_addr = addr;
        @(posedge clk); #1;
        rd_req = 1'b0; rd_addr = ADDR_W'($urandom);
        @(negedge clk); #1;
        check("src_req_set", 32'(m_src_req), 32'd1);
        check("src_addr", 32'(m_src_addr), 32'(addr));
        check("busy_set", 32'(m_busy), 32'd1);
        check("tmo_cleared", 32'(m_tmo), 32'd0);
        check("ovr_cleared", 32'(m_ovr), 32'd0);
        base = stb_total - int'(bit_stb);

        if (ack_delay >= 0) begin
            repeat (ack_delay) @(posedge clk);
            @(posedge clk); #1;
            src_ack = 1'b1; src_data = data;
            @(posedge clk); #1;
            src_ack = 1'b0; src_data = WORD_W'($urandom);
            @(negedge clk); #1;
            check("src_req_dropped", 32'(m_src_req), 32'd0);
            check("tmo_clear_on_ack", 32'(m_tmo), 32'd0);
        end else begin
            for (int c = 0; c < 1000 && !m_tmo; c++) begin
                @(negedge clk); #1;
            end
            check("tmo_set", 32'(m_tmo), 32'd1);
            check("tmo_strobes", 32'(stb_total - int'(bit_stb) - base), 32'(TIMEOUT));
            check("src_req_after_tmo", 32'(m_src_req), 32'd0);
        end

        got_done = 1'b0;
        injected = 1'b0;
        for (int c = 0; c < 3000 && !got_done; c++) begin
            @(negedge clk); #1;
            if (m_done) begin
                got_done = 1'b1;
            end else if (mode == 1 && !injected && cap_q.size() == 5) begin
                injected = 1'b1;
                @(posedge clk); #1;
                rd_req = 1'b1; rd_addr = ~addr;
                @(posedge clk); #1;
                rd_req = 1'b0;
                @(negedge clk); #1;
                check("ovr_set_in_shift", 32'(m_ovr), 32'd1);
                check("addr_kept", 32'(m_src_addr), 32'(addr));
            end else if (mode == 2 && !injected && cap_q.size() == n && bit_stb) begin
                injected = 1'b1;
                @(posedge clk); #1;
                rd_req = 1'b1; rd_addr = ~addr;
                @(negedge clk); #1;
                got_done = m_done;
                @(posedge clk); #1;
                rd_req = 1'b0;
                @(negedge clk); #1;
                check("ovr_on_done", 32'(m_ovr), 32'd1);
                check("no_fetch_on_done", {30'd0, m_src_req, m_busy}, 32'd0);
            end else if (mode == 3 && !injected && cap_q.size() == 10) begin
                injected = 1'b1;
                rst = 1'b1;
                #1;
                check("rst_mid_shift", {26'd0, m_dinf, m_gate, m_busy, m_done, m_tmo, m_ovr}, 32'd0);
                @(posedge clk); #1;
                rst = 1'b0;
                break;
            end
        end
        if (mode == 3) begin
            check("rst_injected", 32'(injected), 32'd1);
            return;
        end

        check("done_seen", 32'(got_done), 32'd1);
        check("bit_count", 32'(cap_at_done), 32'(n));
        check("gate_cycles", 32'(gate_cycles), 32'(n * STB_PERIOD));
        obs_w = '0;
        exp_w = '0;
        for (int i = 0; i < n; i++) begin
            if (i < cap_q.size()) obs_w[i] = cap_q[i];
            exp_w[i] = exp_q[i];
        end
        check("serial_word", obs_w, exp_w);
        @(negedge clk); #1;
        check("done_one_cycle", {29'd0, m_done, m_gate, m_dinf}, 32'd0);
        check("done_count", 32'(done_cnt), 32'd1);
        $display("[TB] read addr=%03h data=%07h ack_delay=%0d mode=%0d bits=%0d par=%0d",
                 addr, data, ack_delay, mode, cap_q.size(), !sel_np);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [WORD_W-1:0] d;
        int                dly;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        check("reset_outputs", {23'd0, m_src_req, m_dinf, m_gate, m_busy, m_done, m_tmo, m_ovr, 2'b00}, 32'd0);
        check("reset_addr", 32'(m_src_addr), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        run_read(9'h1A5, 26'h2AAAAAA, 3, 0);
        run_read(ADDR_W'($urandom), WORD_W'($urandom), -1, 0);
        check("tmo_sticky", 32'(m_tmo), 32'd1);
        run_read(9'h033, 26'h0000001, 5, 1);
        check("ovr_sticky", 32'(m_ovr), 32'd1);
        ghost_en = 1'b1;
        run_read(9'h0F0, WORD_W'($urandom), 17, 0);
        ghost_en = 1'b0;
        run_read(ADDR_W'($urandom), WORD_W'($urandom), 2, 2);
        run_read(ADDR_W'($urandom), WORD_W'($urandom), 4, 3);
        run_read(9'h155, WORD_W'($urandom), 1, 0);

        for (int k = 0; k < 8; k++) begin
            d   = WORD_W'($urandom);
            dly = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, 40));
            ghost_en = bit'($urandom_range(0, 1));
            run_read(ADDR_W'($urandom), d, dly, 0);
        end
        ghost_en = 1'b0;

        sel_np = 1'b1;
        pulse_reset();
        run_read(9'h0AA, 26'h3FFFFFF, 2, 0);
        run_read(ADDR_W'($urandom), WORD_W'($urandom), 9, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
